// File: rtl/xy_mem_pkg.sv
// Shared defaults, FSM state type and size helper for the X/Y coordinate
// bank controller.
package xy_mem_pkg;

    localparam int unsigned DEF_DEPTH  = 256;
    localparam int unsigned DEF_ADDR_W = 8;
    localparam int unsigned DEF_DATA_W = 32;

    typedef enum logic {
        S_CLEAR,
        S_RUN
    } xy_state_t;

    // An arr_size of zero selects the whole bank.
    function automatic int unsigned size_eff_of(input logic [7:0] arr_size,
                                                input int unsigned depth);
        return (arr_size == 8'd0) ? depth : {24'd0, arr_size};
    endfunction

endpackage

// File: rtl/xy_wr_ptr.sv
// Strided, wrapping HPS write pointer with a saturating valid-entry count.
module xy_wr_ptr
    import xy_mem_pkg::*;
#(
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              adv,
    input  logic [7:0]        incr,
    input  logic [7:0]        arr_size,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W:0]   count
);

    logic [ADDR_W:0] ptr_q;
    logic [ADDR_W:0] size_eff;
    logic [ADDR_W:0] nxt;
    logic [ADDR_W:0] cnt_nxt;

    always_comb begin
        size_eff = (ADDR_W+1)'(size_eff_of(arr_size, DEPTH));
        nxt      = ptr_q + (ADDR_W+1)'(incr);
        // A stride larger than the active size can still overshoot after one wrap.
        if (nxt >= size_eff) nxt = nxt - size_eff;
        if (nxt >= size_eff) nxt = '0;
        cnt_nxt  = (count >= size_eff) ? size_eff : count + (ADDR_W+1)'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
            count <= '0;
        end else if (clr) begin
            ptr_q <= '0;
            count <= '0;
        end else if (adv) begin
            ptr_q <= nxt;
            count <= cnt_nxt;
        end
    end

    assign wr_ptr = ptr_q[ADDR_W-1:0];

endmodule

// File: rtl/xy_mem_ctrl.sv
// Sequencer for the X/Y M10K coordinate banks: zero-fill, strided HPS writes,
// single-requester reads. Define XYMEM_RD_BYPASS_EN to forward same-address writes.
module xy_mem_ctrl
    import xy_mem_pkg::*;
#(
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_req,
    output logic              clear_done,
    input  logic              hps_valid,
    output logic              hps_ready,
    input  logic [DATA_W-1:0] hps_x,
    input  logic [DATA_W-1:0] hps_y,
    input  logic [7:0]        incr,
    input  logic [7:0]        arr_size,
    output logic [ADDR_W:0]   count,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_x,
    output logic [DATA_W-1:0] rd_y,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_x_d,
    output logic [DATA_W-1:0] mem_y_d,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] mem_x_q,
    input  logic [DATA_W-1:0] mem_y_q
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    xy_state_t         state;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              rdy_q;
    logic [ADDR_W-1:0] wr_ptr;
    logic              wr_acc;
    logic              rd_acc;
    logic              rd_hazard;

    // clear_req outranks a simultaneous HPS write.
    assign hps_ready = rdy_q & ~clear_req;
    assign wr_acc    = hps_valid & hps_ready;

`ifdef XYMEM_RD_BYPASS_EN
    assign rd_hazard = 1'b0;
`else
    assign rd_hazard = rd_req & wr_acc & (rd_addr == wr_ptr);
`endif

    assign rd_ready  = rdy_q & ~rd_hazard;
    assign rd_acc    = rd_req & rd_ready;

    assign mem_we    = clr_we | wr_acc;
    assign mem_waddr = wr_acc ? wr_ptr : clr_addr;
    assign mem_x_d   = wr_acc ? hps_x : '0;
    assign mem_y_d   = wr_acc ? hps_y : '0;
    assign mem_raddr = rd_addr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_CLEAR;
            clr_we     <= 1'b0;
            clr_addr   <= '0;
            rdy_q      <= 1'b0;
            clear_done <= 1'b0;
            rd_valid   <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            case (state)
                S_CLEAR: begin
                    rdy_q      <= 1'b0;
                    clear_done <= 1'b0;
                    // clr_we low here only on the first cycle out of reset.
                    if (clear_req || !clr_we) begin
                        clr_we   <= 1'b1;
                        clr_addr <= '0;
                    end else if (clr_addr == LAST_ADDR) begin
                        clr_we     <= 1'b0;
                        clear_done <= 1'b1;
                        state      <= S_RUN;
                    end else begin
                        clr_addr <= clr_addr + ADDR_W'(1);
                    end
                end
                S_RUN: begin
                    clear_done <= 1'b0;
                    if (clear_req) begin
                        state    <= S_CLEAR;
                        clr_we   <= 1'b1;
                        clr_addr <= '0;
                        rdy_q    <= 1'b0;
                    end else begin
                        rdy_q <= 1'b1;
                    end
                end
                default: state <= S_CLEAR;
            endcase
        end
    end

    xy_wr_ptr #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_wr_ptr (
        .clk     (clk),
        .reset   (reset),
        .clr     (clear_req),
        .adv     (wr_acc),
        .incr    (incr),
        .arr_size(arr_size),
        .wr_ptr  (wr_ptr),
        .count   (count)
    );

`ifdef XYMEM_RD_BYPASS_EN
    logic              byp_hit;
    logic [DATA_W-1:0] byp_x;
    logic [DATA_W-1:0] byp_y;

    // The bank returns old data on a same-address read-during-write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byp_hit <= 1'b0;
            byp_x   <= '0;
            byp_y   <= '0;
        end else begin
            byp_hit <= rd_acc & wr_acc & (rd_addr == wr_ptr);
            if (wr_acc) begin
                byp_x <= hps_x;
                byp_y <= hps_y;
            end
        end
    end

    always_comb begin
        rd_x = '0;
        rd_y = '0;
        if (rd_valid) begin
            rd_x = byp_hit ? byp_x : mem_x_q;
            rd_y = byp_hit ? byp_y : mem_y_q;
        end
    end
`else
    assign rd_x = rd_valid ? mem_x_q : '0;
    assign rd_y = rd_valid ? mem_y_q : '0;
`endif

endmodule

// File: tb/tb_xy_mem_ctrl.sv
// Directed bench for xy_mem_ctrl with a behavioural pair of 256x32 banks.
module tb_xy_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear_req;
    logic        clear_done;
    logic        hps_valid;
    logic        hps_ready;
    logic [31:0] hps_x;
    logic [31:0] hps_y;
    logic [7:0]  incr;
    logic [7:0]  arr_size;
    logic [8:0]  count;
    logic        rd_req;
    logic [7:0]  rd_addr;
    logic        rd_ready;
    logic        rd_valid;
    logic [31:0] rd_x;
    logic [31:0] rd_y;
    logic        mem_we;
    logic [7:0]  mem_waddr;
    logic [31:0] mem_x_d;
    logic [31:0] mem_y_d;
    logic [7:0]  mem_raddr;
    logic [31:0] mem_x_q;
    logic [31:0] mem_y_q;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    xy_mem_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .clear_req (clear_req),
        .clear_done(clear_done),
        .hps_valid (hps_valid),
        .hps_ready (hps_ready),
        .hps_x     (hps_x),
        .hps_y     (hps_y),
        .incr      (incr),
        .arr_size  (arr_size),
        .count     (count),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_ready  (rd_ready),
        .rd_valid  (rd_valid),
        .rd_x      (rd_x),
        .rd_y      (rd_y),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_x_d   (mem_x_d),
        .mem_y_d   (mem_y_d),
        .mem_raddr (mem_raddr),
        .mem_x_q   (mem_x_q),
        .mem_y_q   (mem_y_q)
    );

    // M10K-style banks: registered read, old data on same-address collision.
    logic [31:0] bank_x [256];
    logic [31:0] bank_y [256];
    always @(posedge clk) begin
        if (mem_we) begin
            bank_x[mem_waddr] <= mem_x_d;
            bank_y[mem_waddr] <= mem_y_d;
        end
        mem_x_q <= bank_x[mem_raddr];
        mem_y_q <= bank_y[mem_raddr];
    end

    function automatic logic [31:0] neg(input int v);
        return 32'(-v);
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_clear_full(input string tag);
        int unsigned waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!mem_we && waited < 4);
        chk({tag, "_start"}, mem_we, 1);
        for (int unsigned k = 0; k < 256; k++) begin
            if (k != 0) @(negedge clk);
            chk({tag, "_fill"}, {mem_we, mem_waddr, mem_x_d, mem_y_d, hps_ready, rd_ready, clear_done},
                {1'b1, 8'(k), 64'd0, 3'b000});
        end
        @(negedge clk);
        chk({tag, "_done"}, {mem_we, clear_done, hps_ready}, 3'b010);
        @(negedge clk);
        chk({tag, "_ready"}, {clear_done, hps_ready, rd_ready, count}, {3'b011, 9'd0});
    endtask

    typedef struct {
        logic [7:0]  arr_size;
        logic [7:0]  incr;
        logic [31:0] x;
        logic [31:0] y;
        logic [7:0]  exp_addr;
        logic [8:0]  exp_count;
    } wvec_t;

    wvec_t vecs [12];
    int    rd_a [4];
    int    rd_e [4];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{8'd5, 8'd2,   32'd100, neg(100), 8'd0, 9'd1};
        vecs[1]  = '{8'd5, 8'd2,   32'd101, neg(101), 8'd2, 9'd2};
        vecs[2]  = '{8'd5, 8'd2,   32'd102, neg(102), 8'd4, 9'd3};
        vecs[3]  = '{8'd5, 8'd2,   32'd103, neg(103), 8'd1, 9'd4};
        vecs[4]  = '{8'd5, 8'd2,   32'd104, neg(104), 8'd3, 9'd5};
        vecs[5]  = '{8'd5, 8'd2,   32'd105, neg(105), 8'd0, 9'd5};
        vecs[6]  = '{8'd3, 8'd1,   32'd106, neg(106), 8'd2, 9'd3};
        vecs[7]  = '{8'd3, 8'd1,   32'd107, neg(107), 8'd0, 9'd3};
        vecs[8]  = '{8'd3, 8'd0,   32'd108, neg(108), 8'd1, 9'd3};
        vecs[9]  = '{8'd3, 8'd0,   32'd109, neg(109), 8'd1, 9'd3};
        vecs[10] = '{8'd4, 8'd200, 32'd110, neg(110), 8'd1, 9'd4};
        vecs[11] = '{8'd4, 8'd200, 32'd111, neg(111), 8'd0, 9'd4};
        rd_a = '{10, 20, 0, 255};
        rd_e = '{10, 20, 256, 255};

        reset = 1'b0; clear_req = 1'b0; hps_valid = 1'b0; hps_x = '0; hps_y = '0;
        incr = '0; arr_size = '0; rd_req = 1'b0; rd_addr = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out", {mem_we, hps_ready, rd_ready, rd_valid, clear_done}, 5'b0);
        chk("rst_rd_data", {rd_x, rd_y}, 64'd0);
        chk("rst_count", count, 0);
        @(posedge clk); #1 reset = 1'b1;
        check_clear_full("boot");

        // Strided modulo pointer and saturating count
        @(posedge clk); #1;
        for (int i = 0; i < 12; i++) begin
            hps_valid = 1'b1; arr_size = vecs[i].arr_size; incr = vecs[i].incr;
            hps_x = vecs[i].x; hps_y = vecs[i].y;
            @(negedge clk);
            chk($sformatf("vec%0d_write", i), {mem_we, mem_waddr, mem_x_d, mem_y_d},
                {1'b1, vecs[i].exp_addr, vecs[i].x, vecs[i].y});
            @(posedge clk); #1;
            chk($sformatf("vec%0d_count", i), count, vecs[i].exp_count);
        end
        hps_valid = 1'b0;

        // clear_req beats a simultaneous write; reset at clear cycle 100 restarts
        clear_req = 1'b1; hps_valid = 1'b1; hps_x = 32'd123; hps_y = 32'd321;
        @(negedge clk);
        chk("clr_drops_write", mem_we, 0);
        @(posedge clk); #1;
        clear_req = 1'b0; hps_valid = 1'b0;
        chk("clr_count_zero", count, 0);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            chk("clr_partial", {mem_we, mem_waddr}, {1'b1, 8'(k)});
        end
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("midclr_reset", {mem_we, mem_waddr, count, clear_done}, 19'd0);
        @(posedge clk); #1 reset = 1'b1;
        check_clear_full("reclear");

        // clear_req during a clear restarts the fill at address 0
        @(posedge clk); #1 clear_req = 1'b1;
        @(posedge clk); #1 clear_req = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            chk("clr_pre_restart", {mem_we, mem_waddr}, {1'b1, 8'(k)});
        end
        @(posedge clk); #1 clear_req = 1'b1;
        @(posedge clk); #1 clear_req = 1'b0;
        check_clear_full("restart");

        // arr_size 0 means the full bank: 257 writes wrap to 0, count saturates at 256
        @(posedge clk); #1;
        arr_size = 8'd0; incr = 8'd1;
        for (int i = 0; i < 257; i++) begin
            hps_valid = 1'b1; hps_x = 32'(i); hps_y = neg(i);
            @(negedge clk);
            chk("full_write", {mem_we, mem_waddr}, {1'b1, 8'(i % 256)});
            @(posedge clk); #1;
            if (i == 255) chk("full_count_256", count, 256);
        end
        hps_valid = 1'b0;
        chk("full_count_sat", count, 256);

        // Write (7,-3) at address 4 then read it back
        hps_valid = 1'b1; hps_x = 32'd11; hps_y = neg(11); incr = 8'd3;
        @(negedge clk);
        chk("w_at1", mem_waddr, 1);
        @(posedge clk); #1;
        hps_x = 32'd7; hps_y = neg(3); incr = 8'd1;
        @(negedge clk);
        chk("w_at4", {mem_we, mem_waddr}, {1'b1, 8'd4});
        @(posedge clk); #1;
        hps_valid = 1'b0; rd_req = 1'b1; rd_addr = 8'd4;
        @(negedge clk);
        chk("rd4_ready", {rd_ready, rd_valid}, 2'b10);
        @(posedge clk); #1 rd_req = 1'b0;
        @(negedge clk);
        chk("rd4_data", {rd_valid, rd_x, rd_y}, {1'b1, 32'd7, neg(3)});
        @(posedge clk); #1;

        // Back-to-back reads at one per cycle
        for (int i = 0; i < 4; i++) begin
            rd_req = 1'b1; rd_addr = 8'(rd_a[i]);
            @(negedge clk);
            chk("stream_ready", rd_ready, 1);
            if (i > 0) chk("stream_data", {rd_valid, rd_x, rd_y}, {1'b1, 32'(rd_e[i-1]), neg(rd_e[i-1])});
            @(posedge clk); #1;
        end
        rd_req = 1'b0;
        @(negedge clk);
        chk("stream_last", {rd_valid, rd_x, rd_y}, {1'b1, 32'd255, neg(255)});
        @(posedge clk); #1;
        @(negedge clk);
        chk("stream_idle", {rd_valid, rd_x}, 33'd0);

        // Same-address read during write at address 2 (old 2, new 9)
        @(posedge clk); #1;
        hps_valid = 1'b1; hps_x = 32'd55; hps_y = neg(55); incr = 8'd253;
        @(negedge clk);
        chk("w_at5", mem_waddr, 5);
        @(posedge clk); #1;
        hps_x = 32'd9; hps_y = neg(9); incr = 8'd1; rd_req = 1'b1; rd_addr = 8'd2;
        @(negedge clk);
        chk("haz_write", {mem_we, mem_waddr}, {1'b1, 8'd2});
`ifdef XYMEM_RD_BYPASS_EN
        chk("haz_rd_ready", rd_ready, 1);
        @(posedge clk); #1 hps_valid = 1'b0; rd_req = 1'b0;
        @(negedge clk);
        chk("haz_bypass_data", {rd_valid, rd_x, rd_y}, {1'b1, 32'd9, neg(9)});
`else
        chk("haz_rd_ready", rd_ready, 0);
        @(posedge clk); #1 hps_valid = 1'b0;
        @(negedge clk);
        chk("haz_retry", {rd_ready, rd_valid}, 2'b10);
        @(posedge clk); #1 rd_req = 1'b0;
        @(negedge clk);
        chk("haz_retry_data", {rd_valid, rd_x, rd_y}, {1'b1, 32'd9, neg(9)});
`endif

        // Different-address read during a write is not stalled
        @(posedge clk); #1;
        hps_valid = 1'b1; hps_x = 32'd33; hps_y = neg(33); rd_req = 1'b1; rd_addr = 8'd10;
        @(negedge clk);
        chk("nohaz", {mem_we, mem_waddr, rd_ready}, {1'b1, 8'd3, 1'b1});
        @(posedge clk); #1 hps_valid = 1'b0; rd_req = 1'b0;
        @(negedge clk);
        chk("nohaz_data", {rd_valid, rd_x, rd_y}, {1'b1, 32'd10, neg(10)});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
